wrr_pktsched: RTL and testbench
===============================

WRR_PKTSCHED -- requirements
Module: wrr_pktsched

Interface
REQ-001 SHALL have parameter NS, default 4: number of packet sources arbitrated.
REQ-002 SHALL have parameter WW, default 4: per-source weight width.
REQ-003 SHALL have parameter MAX_WAIT, default 255: aging threshold in cycles (used only under REQ-030).
REQ-004 SHALL have port S_AXI_ACLK, input, 1: sole clock.
REQ-005 SHALL have port S_AXI_ARESETN, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_req, input, NS: per-source packet request (source TVALID).
REQ-007 SHALL have port i_weight, input, NS*WW: packets per turn, source k at bits [k*WW +: WW].
REQ-008 SHALL have port i_pkt_done, input, 1: pulse when the granted source's LAST beat is accepted.
REQ-009 SHALL have port o_grant, output, NS: one-hot or zero grant.
REQ-010 SHALL have port o_busy, output, 1: a packet is in progress under the current grant.
REQ-011 SHALL have port o_grant_idx, output, clog2(NS): encoded index of the current or last grant.

Function
REQ-012 SHALL implement a two-state FSM: IDLE (o_grant=0, o_busy=0) and BUSY (o_grant one-hot, o_busy=1).
REQ-013 IDLE with |i_req SHALL register a grant and enter BUSY; o_grant is valid the following cycle (1-cycle latency).
REQ-014 BUSY SHALL hold o_grant and o_grant_idx constant until i_pkt_done, regardless of i_req changes.
REQ-015 BUSY with i_pkt_done and |i_req SHALL issue the next grant the following cycle, with no idle gap.
REQ-016 BUSY with i_pkt_done and i_req==0 SHALL return to IDLE and clear o_grant the following cycle.
REQ-017 i_pkt_done in IDLE SHALL be ignored.
REQ-018 SHALL keep a turn pointer and a WW-bit credit counter; each i_pkt_done decrements the counter, saturating at 0.
REQ-019 Selection: the pointer source SHALL keep the grant if its credit > 0 and its i_req is set; otherwise the grant goes to the next requesting source in circular order after the pointer, the pointer moves to it, and its credit loads.
REQ-020 Credit load SHALL be i_weight[k] sampled at turn start; weight 0 SHALL be treated as 1.
REQ-021 A single requester SHALL be granted repeatedly, reloading credit at each turn boundary.
REQ-022 o_grant_idx SHALL retain the last granted index while IDLE.
REQ-023 o_grant SHALL never have more than one bit set.

Reset
REQ-024 Reset assertion SHALL act immediately, independent of the clock.
REQ-025 Reset SHALL force: o_grant=0, o_busy=0, o_grant_idx=0, state IDLE, pointer NS-1 (so source 0 wins first), credit 0, aging counters 0.
REQ-026 Reset asserted mid-packet SHALL drop the grant; the in-progress packet is abandoned, with no recovery state.
REQ-027 The first grant after reset release SHALL occur no earlier than one cycle after the first rising edge with S_AXI_ARESETN high.

Configuration
REQ-028 Macro WRR_PKTSCHED_AGING_EN SHALL select starvation aging.
REQ-029 Without the macro: pure weighted round-robin per REQ-019; no wait counters are synthesized.
REQ-030 With the macro: each source has an 8-bit saturating wait counter.
- Increments each cycle the source requests and is not granted.
- Clears on grant or when i_req drops.
- At any selection, a source with counter >= MAX_WAIT overrides REQ-019; the lowest such index wins; the pointer moves to it and its credit loads.

Verification
REQ-031 Reset, then i_req=4'b0101 with all weights 1: grants alternate 0,2,0,2 per i_pkt_done; first o_grant=4'b0001 one cycle after i_req is seen.
REQ-032 i_req=4'b0011, weights {w0=3,w1=1}: grant sequence 0,0,0,1,0,0,0,1.
REQ-033 BUSY on source 2, i_req[2] drops mid-packet: o_grant stays 4'b0100 until i_pkt_done, then IDLE if i_req=0.
REQ-034 i_pkt_done with i_req=4'b1000 pending: o_grant=4'b1000 on the next cycle, o_busy held at 1.
REQ-035 Reset pulsed during BUSY: o_grant=0 and o_busy=0 immediately; the next grant goes to source 0 when i_req=4'b1111.
REQ-036 With WRR_PKTSCHED_AGING_EN, MAX_WAIT=8, source 0 at weight 15 streaming and source 3 requesting: source 3 is granted at the first i_pkt_done after its counter reaches 8.

Source files
------------

// File: rtl/wrr_pktsched.sv
// Weighted round-robin packet scheduler: grants one source per packet, each source keeps the turn for its weight in packets.
// Optional starvation aging is enabled by defining WRR_PKTSCHED_AGING_EN.
module wrr_pktsched #(
    parameter int NS       = 4,
    parameter int WW       = 4,
    parameter int MAX_WAIT = 255
) (
    input  logic                               S_AXI_ACLK,
    input  logic                               S_AXI_ARESETN,
    input  logic [NS-1:0]                      i_req,
    input  logic [NS*WW-1:0]                   i_weight,
    input  logic                               i_pkt_done,
    output logic [NS-1:0]                      o_grant,
    output logic                               o_busy,
    output logic [(NS > 1 ? $clog2(NS) : 1)-1:0] o_grant_idx
);

    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [NS-1:0]   grant_q, grant_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [WW-1:0]   credit_q, credit_d;

    logic            sel;
    logic [WW-1:0]   cred_eff;
    logic            nxt_found;
    logic [IW-1:0]   nxt_idx;
    logic            aged_found;
    logic [IW-1:0]   aged_idx;

    function automatic logic [WW-1:0] load_credit(input logic [WW-1:0] w);
        return (w == '0) ? WW'(1) : w;
    endfunction

    function automatic logic [WW-1:0] sat_dec(input logic [WW-1:0] c);
        return (c == '0) ? '0 : c - WW'(1);
    endfunction

    // First requesting source strictly after the pointer, wrapping back to the pointer itself last.
    always_comb begin
        int c;
        nxt_found = 1'b0;
        nxt_idx   = ptr_q;
        for (int off = 1; off <= NS; off++) begin
            c = (int'(ptr_q) + off) % NS;
            if (!nxt_found && i_req[c]) begin
                nxt_found = 1'b1;
                nxt_idx   = IW'(c);
            end
        end
    end

`ifdef WRR_PKTSCHED_AGING_EN
    localparam logic [7:0] WAIT_TH = (MAX_WAIT > 255) ? 8'd255 : 8'(MAX_WAIT);

    logic [7:0] wait_q [NS];
    logic [7:0] wait_d [NS];

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            wait_d[k] = wait_q[k];
            if (!i_req[k] || grant_q[k]) begin
                wait_d[k] = 8'd0;
            end else if (wait_q[k] != 8'hFF) begin
                wait_d[k] = wait_q[k] + 8'd1;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int k = 0; k < NS; k++) wait_q[k] <= 8'd0;
        end else begin
            for (int k = 0; k < NS; k++) wait_q[k] <= wait_d[k];
        end
    end

    // Lowest-index starved requester wins an override.
    always_comb begin
        aged_found = 1'b0;
        aged_idx   = '0;
        for (int k = NS - 1; k >= 0; k--) begin
            if (i_req[k] && wait_q[k] >= WAIT_TH) begin
                aged_found = 1'b1;
                aged_idx   = IW'(k);
            end
        end
    end
`else
    // Threshold has no effect without aging; the compare keeps the parameter referenced.
    always_comb begin
        aged_found = (MAX_WAIT < 0);
        aged_idx   = '0;
    end
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        cred_eff = credit_q;
        sel      = 1'b0;

        case (state_q)
            IDLE: begin
                if (|i_req) sel = 1'b1;
            end
            BUSY: begin
                if (i_pkt_done) begin
                    cred_eff = sat_dec(credit_q);
                    credit_d = cred_eff;
                    if (|i_req) begin
                        sel = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (sel) begin
            state_d = BUSY;
            if (aged_found) begin
                ptr_d    = aged_idx;
                credit_d = load_credit(i_weight[int'(aged_idx)*WW +: WW]);
            end else if (i_req[ptr_q] && cred_eff != '0) begin
                ptr_d    = ptr_q;
                credit_d = cred_eff;
            end else begin
                ptr_d    = nxt_idx;
                credit_d = load_credit(i_weight[int'(nxt_idx)*WW +: WW]);
            end
            grant_d        = '0;
            grant_d[ptr_d] = 1'b1;
            idx_d          = ptr_d;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            ptr_q    <= IW'(NS - 1);
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
        end
    end

    assign o_grant     = grant_q;
    assign o_busy      = (state_q == BUSY);
    assign o_grant_idx = idx_q;

endmodule

// File: tb/tb_wrr_pktsched.sv
// Directed-vector bench for wrr_pktsched with hand-computed grant sequences.
module tb_wrr_pktsched;

    localparam int NS = 4;
    localparam int WW = 4;

    logic          clk;
    logic          rst_n;
    logic [NS-1:0] req;
    logic [NS*WW-1:0] weight;
    logic          done;
    logic [NS-1:0] grant;
    logic          busy;
    logic [1:0]    gidx;

    int n_vec = 0;
    int n_err = 0;

    wrr_pktsched #(.NS(NS), .WW(WW), .MAX_WAIT(8)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .i_req         (req),
        .i_weight      (weight),
        .i_pkt_done    (done),
        .o_grant       (grant),
        .o_busy        (busy),
        .o_grant_idx   (gidx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    logic [3:0] seq32 [7];

    initial begin
        seq32 = '{4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        rst_n  = 1'b0;
        req    = '0;
        weight = '0;
        done   = 1'b0;
        repeat (3) tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_idx",   32'(gidx),  32'h0);

        // Alternating 0,2 with unit weights
        rst_n  = 1'b1;
        weight = 16'h1111;
        req    = 4'b0101;
        check("pre_first_grant", 32'(grant), 32'h0);
        tick();
        check("first_grant", 32'(grant), 32'h1);
        check("first_busy",  32'(busy),  32'h1);
        check("first_idx",   32'(gidx),  32'h0);
        tick();
        check("hold_no_done", 32'(grant), 32'h1);
        pulse_done();
        check("alt_1", 32'(grant), 32'h4);
        pulse_done();
        check("alt_2", 32'(grant), 32'h1);
        pulse_done();
        check("alt_3", 32'(grant), 32'h4);
        check("alt_3_idx", 32'(gidx), 32'h2);

        // Request drop while busy, then return to idle
        req = 4'b0000;
        tick();
        check("hold_req_drop", 32'(grant), 32'h4);
        pulse_done();
        check("idle_grant", 32'(grant), 32'h0);
        check("idle_busy",  32'(busy),  32'h0);
        check("idle_idx_retained", 32'(gidx), 32'h2);
        pulse_done();
        check("done_in_idle", 32'(grant), 32'h0);
        check("done_in_idle_busy", 32'(busy), 32'h0);

        // Weighted sequence w0=3, w1=1
        weight = 16'h0013;
        req    = 4'b0011;
        tick();
        check("wrr_first", 32'(grant), 32'h1);
        for (int i = 0; i < 7; i++) begin
            pulse_done();
            check($sformatf("wrr_seq_%0d", i), 32'(grant), 32'(seq32[i]));
        end

        // Busy on source 2, requester leaves mid-packet
        weight = 16'h1111;
        req    = 4'b0100;
        pulse_done();
        check("src2_grant", 32'(grant), 32'h4);
        req = 4'b0000;
        tick();
        tick();
        check("src2_hold", 32'(grant), 32'h4);
        check("src2_busy", 32'(busy),  32'h1);
        pulse_done();
        check("src2_release", 32'(grant), 32'h0);

        // Back-to-back handoff to a pending source 3
        req = 4'b0001;
        tick();
        check("src0_grant", 32'(grant), 32'h1);
        req = 4'b1000;
        pulse_done();
        check("handoff_grant", 32'(grant), 32'h8);
        check("handoff_busy",  32'(busy),  32'h1);
        check("handoff_idx",   32'(gidx),  32'h3);

        // Asynchronous reset mid-packet
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_grant", 32'(grant), 32'h0);
        check("async_rst_busy",  32'(busy),  32'h0);
        check("async_rst_idx",   32'(gidx),  32'h0);
        tick();
        rst_n = 1'b1;
        req   = 4'b1111;
        check("post_rst_pre", 32'(grant), 32'h0);
        tick();
        check("post_rst_grant", 32'(grant), 32'h1);

        // Heavy source 0 against a waiting source 3
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        weight = 16'h100F;
        req    = 4'b1001;
        tick();
        check("age_first", 32'(grant), 32'h1);
        repeat (10) tick();
        pulse_done();
`ifdef WRR_PKTSCHED_AGING_EN
        check("age_override", 32'(grant), 32'h8);
`else
        check("no_age_keep", 32'(grant), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
